// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority/alpha pixel compositor with 3-stage pipeline
//
// Purpose:
//   Places N_LAYERS sprite layers over a background colour. Per pixel the
//   highest-priority (lowest index) enabled layer that covers the pixel is
//   selected and either shown opaquely (mode 0) or alpha-blended over the
//   background (mode 1). Layer enables and mode are double-buffered: writes
//   land in shadow registers and are copied to the active set on the rising
//   edge of i_v_sync. Output is a fixed 3-cycle pipeline with aligned x/y/valid.
//
// Ports:
//   i_clk, i_rst                  pixel clock, asynchronous active-low reset
//   i_x, i_y, i_valid             pixel coordinates and qualifier
//   i_v_sync                      vertical sync, rising edge = frame boundary
//   i_bg_rgb                      background colour {r,g,b}
//   i_layer_rgb                   per-layer colours, layer k in slice k
//   i_layer_hit                   per-layer coverage of this pixel
//   i_layer_alpha                 per-layer alpha
//   i_cfg_wr, i_cfg_en, i_cfg_mode  shadow config write
//   o_x, o_y, o_valid             inputs delayed by 3 cycles
//   o_red, o_green, o_blue        composited colour (0 when o_valid=0)
//   o_done                        pulse on the last active pixel of a frame
//   o_frame_cnt                   number of frame boundaries seen
module layer_compositor #(
  parameter int N_LAYERS = 4,
  parameter int COLOR_W  = 8,
  parameter int ALPHA_W  = 4,
  parameter int COORD_W  = 16,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [COORD_W-1:0]              i_x,
  input  logic [COORD_W-1:0]              i_y,
  input  logic                            i_valid,
  input  logic                            i_v_sync,
  input  logic [3*COLOR_W-1:0]            i_bg_rgb,
  input  logic [N_LAYERS*3*COLOR_W-1:0]   i_layer_rgb,
  input  logic [N_LAYERS-1:0]             i_layer_hit,
  input  logic [N_LAYERS*ALPHA_W-1:0]     i_layer_alpha,
  input  logic                            i_cfg_wr,
  input  logic [N_LAYERS-1:0]             i_cfg_en,
  input  logic                            i_cfg_mode,
  output logic [COORD_W-1:0]              o_x,
  output logic [COORD_W-1:0]              o_y,
  output logic                            o_valid,
  output logic [COLOR_W-1:0]              o_red,
  output logic [COLOR_W-1:0]              o_green,
  output logic [COLOR_W-1:0]              o_blue,
  output logic                            o_done,
  output logic [15:0]                     o_frame_cnt
);

  localparam int RGB_W  = 3 * COLOR_W;
  localparam int PROD_W = COLOR_W + ALPHA_W + 1;
  localparam int SEL_W  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam logic [ALPHA_W-1:0] ALPHA_MAX = '1;
  localparam logic [ALPHA_W:0]   ALPHA_ONE = {1'b1, {ALPHA_W{1'b0}}};
  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_Y    = COORD_W'(V_ACTIVE - 1);

  // ---------------------------------------------------------------- config
  logic                r_vs_q;
  logic [N_LAYERS-1:0] r_sh_en;
  logic                r_sh_mode;
  logic [N_LAYERS-1:0] r_act_en;
  logic                r_act_mode;
  logic                w_rise;

  assign w_rise = i_v_sync & ~r_vs_q;

  // Active config copies the shadow value as it stood before this edge, so a
  // write coincident with a boundary only becomes active at the next boundary.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_vs_q      <= 1'b0;
      r_sh_en     <= '1;
      r_sh_mode   <= 1'b0;
      r_act_en    <= '1;
      r_act_mode  <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      r_vs_q <= i_v_sync;
      if (i_cfg_wr) begin
        r_sh_en   <= i_cfg_en;
        r_sh_mode <= i_cfg_mode;
      end
      if (w_rise) begin
        r_act_en    <= r_sh_en;
        r_act_mode  <= r_sh_mode;
        o_frame_cnt <= o_frame_cnt + 16'd1;
      end
    end
  end

  // --------------------------------------------------------------- stage 1
  logic [N_LAYERS-1:0] w_eff_hit;
  logic [SEL_W-1:0]    w_sel;

  assign w_eff_hit = i_layer_hit & r_act_en;

  // Scan from the lowest priority upward so the lowest hit index wins.
  always_comb begin
    w_sel = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (w_eff_hit[k]) w_sel = SEL_W'(k);
    end
  end

  logic                          r1_valid;
  logic [COORD_W-1:0]            r1_x;
  logic [COORD_W-1:0]            r1_y;
  logic [RGB_W-1:0]              r1_bg;
  logic [N_LAYERS*RGB_W-1:0]     r1_rgb;
  logic [N_LAYERS*ALPHA_W-1:0]   r1_alpha;
  logic [SEL_W-1:0]              r1_sel;
  logic                          r1_any;
  logic                          r1_mode;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r1_valid <= 1'b0;
      r1_x     <= '0;
      r1_y     <= '0;
      r1_bg    <= '0;
      r1_rgb   <= '0;
      r1_alpha <= '0;
      r1_sel   <= '0;
      r1_any   <= 1'b0;
      r1_mode  <= 1'b0;
    end else begin
      r1_valid <= i_valid;
      r1_x     <= i_x;
      r1_y     <= i_y;
      r1_bg    <= i_bg_rgb;
      r1_rgb   <= i_layer_rgb;
      r1_alpha <= i_layer_alpha;
      r1_sel   <= w_sel;
      r1_any   <= |w_eff_hit;
      r1_mode  <= r_act_mode;
    end
  end

  // --------------------------------------------------------------- stage 2
  logic [RGB_W-1:0]   w_fg;
  logic [ALPHA_W-1:0] w_a;
  logic [ALPHA_W:0]   w_inv_a;
  logic               w_bypass;
  logic [RGB_W-1:0]   w_bypass_rgb;
  logic [3*PROD_W-1:0] w_pfg;
  logic [3*PROD_W-1:0] w_pbg;

  always_comb begin
    w_fg = '0;
    w_a  = '0;
    for (int k = 0; k < N_LAYERS; k++) begin
      if (r1_sel == SEL_W'(k)) begin
        w_fg = r1_rgb[k*RGB_W +: RGB_W];
        w_a  = r1_alpha[k*ALPHA_W +: ALPHA_W];
      end
    end
  end

  assign w_inv_a = ALPHA_ONE - {1'b0, w_a};

  // Cases with an exact answer skip the blend arithmetic; full alpha must be
  // exactly fg even though (fg*max + bg) >> ALPHA_W would not be.
  always_comb begin
    w_bypass     = 1'b1;
    w_bypass_rgb = w_fg;
    if (!r1_any) begin
      w_bypass_rgb = r1_bg;
    end else if (!r1_mode || w_a == ALPHA_MAX) begin
      w_bypass_rgb = w_fg;
    end else if (w_a == '0) begin
      w_bypass_rgb = r1_bg;
    end else begin
      w_bypass = 1'b0;
    end
  end

  always_comb begin
    w_pfg = '0;
    w_pbg = '0;
    for (int c = 0; c < 3; c++) begin
      w_pfg[c*PROD_W +: PROD_W] = PROD_W'(w_fg[c*COLOR_W +: COLOR_W]) * PROD_W'(w_a);
      w_pbg[c*PROD_W +: PROD_W] = PROD_W'(r1_bg[c*COLOR_W +: COLOR_W]) * PROD_W'(w_inv_a);
    end
  end

  logic                r2_valid;
  logic [COORD_W-1:0]  r2_x;
  logic [COORD_W-1:0]  r2_y;
  logic                r2_bypass;
  logic [RGB_W-1:0]    r2_bypass_rgb;
  logic [3*PROD_W-1:0] r2_pfg;
  logic [3*PROD_W-1:0] r2_pbg;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r2_valid      <= 1'b0;
      r2_x          <= '0;
      r2_y          <= '0;
      r2_bypass     <= 1'b0;
      r2_bypass_rgb <= '0;
      r2_pfg        <= '0;
      r2_pbg        <= '0;
    end else begin
      r2_valid      <= r1_valid;
      r2_x          <= r1_x;
      r2_y          <= r1_y;
      r2_bypass     <= w_bypass;
      r2_bypass_rgb <= w_bypass_rgb;
      r2_pfg        <= w_pfg;
      r2_pbg        <= w_pbg;
    end
  end

  // --------------------------------------------------------------- stage 3
  logic [PROD_W-1:0] w_sum [3];
  logic [RGB_W-1:0]  w_blend;
  logic [RGB_W-1:0]  w_rgb3;

  // fg*a + bg*(2^A - a) never exceeds (2^C - 1) * 2^A, so PROD_W holds the sum.
  always_comb begin
    w_blend = '0;
    for (int c = 0; c < 3; c++) begin
      w_sum[c] = r2_pfg[c*PROD_W +: PROD_W] + r2_pbg[c*PROD_W +: PROD_W];
      w_blend[c*COLOR_W +: COLOR_W] = COLOR_W'(w_sum[c] >> ALPHA_W);
    end
  end

  assign w_rgb3 = r2_bypass ? r2_bypass_rgb : w_blend;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_valid <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_red   <= '0;
      o_green <= '0;
      o_blue  <= '0;
      o_done  <= 1'b0;
    end else begin
      o_valid <= r2_valid;
      o_x     <= r2_x;
      o_y     <= r2_y;
      o_red   <= r2_valid ? w_rgb3[2*COLOR_W +: COLOR_W] : '0;
      o_green <= r2_valid ? w_rgb3[1*COLOR_W +: COLOR_W] : '0;
      o_blue  <= r2_valid ? w_rgb3[0*COLOR_W +: COLOR_W] : '0;
      o_done  <= r2_valid && (r2_x == LAST_X) && (r2_y == LAST_Y);
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - self-checking bench for layer_compositor
module tb_layer_compositor;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_x, i_y;
  logic        i_valid, i_v_sync;
  logic [23:0] i_bg_rgb;
  logic [95:0] i_layer_rgb;
  logic [3:0]  i_layer_hit;
  logic [15:0] i_layer_alpha;
  logic        i_cfg_wr;
  logic [3:0]  i_cfg_en;
  logic        i_cfg_mode;
  logic [15:0] o_x, o_y;
  logic        o_valid;
  logic [7:0]  o_red, o_green, o_blue;
  logic        o_done;
  logic [15:0] o_frame_cnt;

  always #5 i_clk = ~i_clk;

  layer_compositor dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_x(i_x), .i_y(i_y), .i_valid(i_valid),
    .i_v_sync(i_v_sync), .i_bg_rgb(i_bg_rgb), .i_layer_rgb(i_layer_rgb),
    .i_layer_hit(i_layer_hit), .i_layer_alpha(i_layer_alpha), .i_cfg_wr(i_cfg_wr),
    .i_cfg_en(i_cfg_en), .i_cfg_mode(i_cfg_mode), .o_x(o_x), .o_y(o_y),
    .o_valid(o_valid), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_done(o_done), .o_frame_cnt(o_frame_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0]  m_sh_en, m_act_en;
  logic        m_sh_mode, m_act_mode, m_vs_q;
  logic [15:0] m_cnt;
  logic [57:0] q[$];   // {valid, x, y, rgb, done} per presented cycle

  function automatic logic [23:0] model_rgb(input logic [23:0] bg, input logic [95:0] rgb,
                                            input logic [3:0] hit, input logic [15:0] alpha,
                                            input logic [3:0] en, input logic mode);
    logic [3:0]  eff;
    logic [23:0] fg, res;
    int k, a, f, b;
    eff = hit & en;
    if (eff == 4'b0) return bg;
    k = 0;
    while (!eff[k]) k++;
    fg = rgb[k*24 +: 24];
    a  = int'(alpha[k*4 +: 4]);
    if (!mode || a == 15) return fg;
    for (int ch = 0; ch < 3; ch++) begin
      f = int'(fg[ch*8 +: 8]);
      b = int'(bg[ch*8 +: 8]);
      res[ch*8 +: 8] = 8'((f * a + b * (16 - a)) / 16);
    end
    return res;
  endfunction

  function automatic logic [73:0] obs();
    return {o_valid, o_x, o_y, o_red, o_green, o_blue, o_done, o_frame_cnt};
  endfunction

  task automatic idle();
    i_x = 0; i_y = 0; i_valid = 0; i_v_sync = 0; i_bg_rgb = 0; i_layer_rgb = 0;
    i_layer_hit = 0; i_layer_alpha = 0; i_cfg_wr = 0; i_cfg_en = 0; i_cfg_mode = 0;
  endtask

  task automatic model_reset();
    m_sh_en = 4'hF; m_act_en = 4'hF; m_sh_mode = 0; m_act_mode = 0; m_vs_q = 0; m_cnt = 0;
    q.delete();
    q.push_back(58'd0);
    q.push_back(58'd0);
  endtask

  // Present current inputs for one clock; return what the outputs must show now.
  task automatic tick(output logic [73:0] e);
    logic        rise;
    logic [23:0] c;
    rise = i_v_sync & ~m_vs_q;
    c = i_valid ? model_rgb(i_bg_rgb, i_layer_rgb, i_layer_hit, i_layer_alpha, m_act_en, m_act_mode) : 24'h0;
    q.push_back({i_valid, i_x, i_y, c, i_valid && i_x == 16'd639 && i_y == 16'd479});
    @(posedge i_clk);
    if (rise) begin
      m_act_en = m_sh_en; m_act_mode = m_sh_mode; m_cnt = m_cnt + 16'd1;
    end
    if (i_cfg_wr) begin
      m_sh_en = i_cfg_en; m_sh_mode = i_cfg_mode;
    end
    m_vs_q = i_v_sync;
    #1;
    e = {q.pop_front(), m_cnt};
  endtask

  task automatic run_pixel(output logic [73:0] e, output logic [73:0] o);
    i_valid = 1'b1;
    tick(e);
    i_valid = 1'b0;
    tick(e);
    tick(e);
    o = obs();
  endtask

  task automatic frame_pulse();
    logic [73:0] e;
    i_v_sync = 1'b1; tick(e);
    i_v_sync = 1'b0; tick(e);
  endtask

  task automatic test_reset();
    logic [73:0] e;
    idle();
    i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    n_checks++;
    if (obs() !== 74'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", obs());
    end
    i_rst = 1'b1;
    model_reset();
    i_x = 16'd5; i_y = 16'd7; i_bg_rgb = 24'h445566;
    for (int i = 0; i < 4; i++) begin
      i_valid = (i == 0);
      tick(e);
      n_checks++;
      if (o_valid !== (i == 2)) begin
        n_fail++; $display("FAIL latency_valid cycle %0d: got %b want %b", i + 1, o_valid, i == 2);
      end
      n_checks++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL reset_release cycle %0d: got %h want %h", i + 1, obs(), e);
      end
    end
  endtask

  task automatic test_mode0();
    logic [73:0] e, o;
    idle();
    i_x = 16'd10; i_y = 16'd10; i_bg_rgb = 24'h102030; i_layer_hit = 4'b0110;
    i_layer_rgb[1*24 +: 24] = 24'hFF0000;
    i_layer_rgb[2*24 +: 24] = 24'h00FF00;
    i_layer_alpha = 16'h3579;
    run_pixel(e, o);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'hFF0000) begin
      n_fail++; $display("FAIL mode0_priority: got %h want ff0000", {o_red, o_green, o_blue});
    end
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL mode0_model: got %h want %h", o, e); end
  endtask

  task automatic test_mode1();
    logic [73:0] e, o;
    logic [3:0]  av [3];
    logic [23:0] ev [3];
    av = '{4'd8, 4'd15, 4'd0};
    ev = '{24'h808080, 24'hF0F0F0, 24'h101010};
    idle();
    i_cfg_wr = 1; i_cfg_en = 4'hF; i_cfg_mode = 1;
    tick(e);
    i_cfg_wr = 0;
    frame_pulse();
    for (int j = 0; j < 3; j++) begin
      i_x = 16'(20 + j); i_y = 16'd3; i_bg_rgb = 24'h101010; i_layer_hit = 4'b0001;
      i_layer_rgb = {72'h0, 24'hF0F0F0};
      i_layer_alpha = {12'hABC, av[j]};
      run_pixel(e, o);
      n_checks++;
      if ({o_red, o_green, o_blue} !== ev[j]) begin
        n_fail++; $display("FAIL mode1_alpha a=%0d: got %h want %h", av[j], {o_red, o_green, o_blue}, ev[j]);
      end
      n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL mode1_model a=%0d: got %h want %h", av[j], o, e); end
    end
  endtask

  task automatic test_cfg_midframe();
    logic [73:0] e, o;
    logic [15:0] cnt0;
    idle();
    i_cfg_wr = 1; i_cfg_en = 4'hF; i_cfg_mode = 0;
    tick(e);
    i_cfg_wr = 0;
    frame_pulse();
    i_cfg_wr = 1; i_cfg_en = 4'b1110;
    tick(e);
    i_cfg_wr = 0;
    i_x = 16'd100; i_y = 16'd50; i_bg_rgb = 24'h123456; i_layer_hit = 4'b0001;
    i_layer_rgb = {72'h0, 24'hABCDEF}; i_layer_alpha = 16'h0005;
    run_pixel(e, o);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'hABCDEF) begin
      n_fail++; $display("FAIL cfg_before_vsync: got %h want abcdef", {o_red, o_green, o_blue});
    end
    cnt0 = m_cnt;
    frame_pulse();
    run_pixel(e, o);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'h123456) begin
      n_fail++; $display("FAIL cfg_after_vsync: got %h want 123456", {o_red, o_green, o_blue});
    end
    n_checks++;
    if (o_frame_cnt !== cnt0 + 16'd1) begin
      n_fail++; $display("FAIL frame_cnt_inc: got %0d want %0d", o_frame_cnt, cnt0 + 16'd1);
    end
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL cfg_model: got %h want %h", o, e); end
  endtask

  task automatic test_cfg_coincident();
    logic [73:0] e, o;
    idle();
    i_cfg_wr = 1; i_cfg_en = 4'b1101;
    tick(e);
    i_cfg_en = 4'b1111; i_v_sync = 1;
    tick(e);
    i_cfg_wr = 0; i_v_sync = 0;
    tick(e);
    i_x = 16'd7; i_y = 16'd8; i_bg_rgb = 24'h0A0B0C; i_layer_hit = 4'b0010;
    i_layer_rgb = {48'h0, 24'h778899, 24'h0};
    run_pixel(e, o);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'h0A0B0C) begin
      n_fail++; $display("FAIL coincident_old_shadow: got %h want 0a0b0c", {o_red, o_green, o_blue});
    end
    frame_pulse();
    run_pixel(e, o);
    n_checks++;
    if ({o_red, o_green, o_blue} !== 24'h778899) begin
      n_fail++; $display("FAIL coincident_new_later: got %h want 778899", {o_red, o_green, o_blue});
    end
    n_checks++;
    if (o !== e) begin n_fail++; $display("FAIL coincident_model: got %h want %h", o, e); end
  endtask

  task automatic test_done();
    logic [73:0] e;
    logic [15:0] xs [4];
    logic [15:0] ys [4];
    logic        vs [4];
    int          want [4];
    int          pulses, at;
    xs = '{16'd639, 16'd639, 16'd640, 16'd639};
    ys = '{16'd479, 16'd479, 16'd479, 16'd478};
    vs = '{1'b1, 1'b0, 1'b1, 1'b1};
    want = '{1, 0, 0, 0};
    idle();
    for (int s = 0; s < 4; s++) begin
      pulses = 0; at = -1;
      i_x = xs[s]; i_y = ys[s];
      for (int i = 0; i < 5; i++) begin
        i_valid = vs[s] && (i == 0);
        tick(e);
        if (o_done === 1'b1) begin pulses++; at = i; end
      end
      n_checks++;
      if (pulses != want[s] || (want[s] == 1 && at != 2)) begin
        n_fail++; $display("FAIL done_pulse case %0d: got %0d pulses at %0d want %0d", s, pulses, at, want[s]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [73:0] e;
    int errs;
    errs = 0;
    idle();
    for (int i = 0; i < 1500; i++) begin
      i_valid       = ($urandom_range(0, 9) != 0);
      i_x           = ($urandom_range(0, 3) == 0) ? 16'd639 : 16'($urandom_range(0, 700));
      i_y           = ($urandom_range(0, 3) == 0) ? 16'd479 : 16'($urandom_range(0, 500));
      i_bg_rgb      = 24'($urandom);
      i_layer_rgb   = {$urandom, $urandom, $urandom};
      i_layer_hit   = 4'($urandom);
      i_layer_alpha = 16'($urandom);
      i_cfg_wr      = ($urandom_range(0, 29) == 0);
      i_cfg_en      = 4'($urandom);
      i_cfg_mode    = 1'($urandom);
      if ($urandom_range(0, 24) == 0) i_v_sync = ~i_v_sync;
      tick(e);
      n_checks++;
      if (obs() !== e) begin
        n_fail++; errs++;
        if (errs <= 10) $display("FAIL random cycle %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [73:0] e;
    idle();
    i_layer_hit = 4'b0001; i_layer_rgb = {72'h0, 24'h5A5A5A}; i_valid = 1;
    i_x = 16'd638; i_y = 16'd479;
    tick(e);
    i_x = 16'd639;
    tick(e);
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (obs() !== 74'd0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", obs());
    end
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      tick(e);
      n_checks++;
      if (o_valid !== 1'b0 || o_done !== 1'b0 || obs() !== e) begin
        n_fail++; $display("FAIL flush_after_reset cycle %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_cfg_midframe();
    test_cfg_coincident();
    test_done();
    test_back_to_back();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
